// File: rtl/alu_selftest.sv
// BIST initiator for the EX-stage ALU: corner vectors, then LFSR operands, checked against a golden model.
// Two cycles per vector (DRIVE, CHECK), done 2*NUM_VECTORS cycles after start; no backpressure, start ignored while busy.
module alu_selftest #(
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [31:0] SEED        = 32'hACE12345
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [2:0]  control,
   input  logic [31:0] result,
   input  logic        zero,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [15:0] first_fail_idx
);

   localparam logic [31:0] TAPS     = 32'h80200003;
   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [15:0] idx_q;
   logic [2:0]  op_q;
   logic [31:0] lfsr_a_q, lfsr_b_q;
   logic [31:0] a_q, b_q;
   logic [2:0]  ctl_q;
   logic        busy_q, done_q, pass_q;
   logic [15:0] err_q, ffi_q;

   logic [31:0] vec_a_d, vec_b_d;
   logic [2:0]  vec_ctl_d;
   logic [31:0] lfsr_a_d, lfsr_b_d;
   logic [31:0] exp_res;
   logic        mismatch;
   logic [15:0] err_d;
   logic        corner;

   always_comb begin
      corner = (idx_q < 16'd5);

      // op_q tracks idx mod 5 without a divider
      case (op_q)
         3'd0:    vec_ctl_d = OP_ADD;
         3'd1:    vec_ctl_d = OP_SUB;
         3'd2:    vec_ctl_d = OP_AND;
         3'd3:    vec_ctl_d = OP_OR;
         default: vec_ctl_d = OP_SLT;
      endcase

      vec_a_d = lfsr_a_q;
      vec_b_d = (idx_q[2:0] == 3'd0) ? lfsr_a_q : lfsr_b_q;
      if (corner) begin
         case (idx_q[2:0])
            3'd0: begin
               vec_a_d = 32'h0000_0000;
               vec_b_d = 32'h0000_0000;
            end
            3'd1: begin
               vec_a_d = 32'hFFFF_FFFF;
               vec_b_d = 32'h0000_0001;
            end
            3'd3: begin
               vec_a_d = 32'h0F0F_0F0F;
               vec_b_d = 32'hF0F0_F0F0;
            end
            default: begin
               vec_a_d = 32'h8000_0000;
               vec_b_d = 32'h7FFF_FFFF;
            end
         endcase
      end

      lfsr_a_d = lfsr_a_q[0] ? ((lfsr_a_q >> 1) ^ TAPS) : (lfsr_a_q >> 1);
      lfsr_b_d = lfsr_b_q[0] ? ((lfsr_b_q >> 1) ^ TAPS) : (lfsr_b_q >> 1);

      case (ctl_q)
         OP_ADD:  exp_res = a_q + b_q;
         OP_SUB:  exp_res = a_q - b_q;
         OP_AND:  exp_res = a_q & b_q;
         OP_OR:   exp_res = a_q | b_q;
         OP_SLT:  exp_res = {31'd0, ($signed(a_q) < $signed(b_q))};
         default: exp_res = 32'd0;
      endcase

      mismatch = (result != exp_res) || (zero != (exp_res == 32'd0));

      err_d = err_q;
      if (mismatch && (err_q != 16'hFFFF)) begin
         err_d = err_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= 16'd0;
         op_q     <= 3'd0;
         lfsr_a_q <= SEED;
         lfsr_b_q <= ~SEED;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         ctl_q    <= 3'b000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= 16'd0;
         ffi_q    <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q  <= S_DRIVE;
                  idx_q    <= 16'd0;
                  op_q     <= 3'd0;
                  lfsr_a_q <= SEED;
                  lfsr_b_q <= ~SEED;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  err_q    <= 16'd0;
                  ffi_q    <= 16'd0;
               end
            end
            S_DRIVE: begin
               a_q     <= vec_a_d;
               b_q     <= vec_b_d;
               ctl_q   <= vec_ctl_d;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (mismatch) begin
                  err_q <= err_d;
                  if (err_q == 16'd0) begin
                     ffi_q <= idx_q;
                  end
               end
               if (!corner) begin
                  lfsr_a_q <= lfsr_a_d;
                  lfsr_b_q <= lfsr_b_d;
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == 16'd0) && !mismatch;
               end else begin
                  idx_q   <= idx_q + 16'd1;
                  op_q    <= (op_q == 3'd4) ? 3'd0 : op_q + 3'd1;
                  state_q <= S_DRIVE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a              = a_q;
   assign b              = b_q;
   assign control        = ctl_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: a behavioural ALU (optionally faulty) closes the loop; a queue-based model
// predicts every driven vector, the final error count and the first failing index.
module tb_alu_selftest;

   localparam logic [31:0] SEED = 32'hACE12345;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic startd = 1'b0, start5 = 1'b0;
   int   fault = 0;

   logic [31:0] ad, bd, rd, a5, b5, r5;
   logic [2:0]  cd, c5;
   logic        zd, z5;
   logic        busyd, doned, passd, busy5, done5, pass5;
   logic [15:0] errd, ffid, err5, ffi5;

   always #5 clk = ~clk;

   alu_selftest #(.NUM_VECTORS(256), .SEED(SEED)) u_dut (
      .clk(clk), .rst(rst), .start(startd),
      .a(ad), .b(bd), .control(cd), .result(rd), .zero(zd),
      .busy(busyd), .done(doned), .pass(passd),
      .err_count(errd), .first_fail_idx(ffid)
   );

   alu_selftest #(.NUM_VECTORS(5), .SEED(SEED)) u_dut5 (
      .clk(clk), .rst(rst), .start(start5),
      .a(a5), .b(b5), .control(c5), .result(r5), .zero(z5),
      .busy(busy5), .done(done5), .pass(pass5),
      .err_count(err5), .first_fail_idx(ffi5)
   );

   // Golden ALU semantics
   function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
      case (op)
         3'b010:  return x + y;
         3'b110:  return x - y;
         3'b000:  return x & y;
         3'b001:  return x | y;
         3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // ALU under test: fault 1 = unsigned slt, fault 2 = zero stuck at 0
   function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op, input int f);
      logic [31:0] r;
      r = ref_alu(x, y, op);
      if (f == 1 && op == 3'b111) r = (x < y) ? 32'd1 : 32'd0;
      return {(f == 2) ? 1'b0 : (r == 32'd0), r};
   endfunction

   assign {zd, rd} = alu_fn(ad, bd, cd, fault);
   assign {z5, r5} = alu_fn(a5, b5, c5, fault);

   logic        sel5 = 1'b0;
   logic [31:0] v_a, v_b, v_r;
   logic [2:0]  v_c;
   logic        v_busy, v_done, v_pass;
   logic [15:0] v_err, v_ffi;
   assign v_a    = sel5 ? a5 : ad;
   assign v_b    = sel5 ? b5 : bd;
   assign v_c    = sel5 ? c5 : cd;
   assign v_r    = sel5 ? r5 : rd;
   assign v_busy = sel5 ? busy5 : busyd;
   assign v_done = sel5 ? done5 : doned;
   assign v_pass = sel5 ? pass5 : passd;
   assign v_err  = sel5 ? err5 : errd;
   assign v_ffi  = sel5 ? ffi5 : ffid;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [31:0] m_a[$], m_b[$];
   logic [2:0]  m_c[$];
   int          exp_err, exp_ffi;

   // Vector list from the stated rules, plus predicted outcome against the current ALU fault
   task automatic build_model(input int n);
      logic [31:0] ca[5] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h0F0F0F0F, 32'h80000000};
      logic [31:0] cb[5] = '{32'h0, 32'h00000001, 32'h7FFFFFFF, 32'hF0F0F0F0, 32'h7FFFFFFF};
      logic [2:0]  ops[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      logic [31:0] la, lb, g;
      logic [32:0] o;
      m_a.delete(); m_b.delete(); m_c.delete();
      la = SEED; lb = ~SEED;
      exp_err = 0; exp_ffi = 0;
      for (int i = 0; i < n; i++) begin
         if (i < 5) begin
            m_a.push_back(ca[i]); m_b.push_back(cb[i]);
         end else begin
            m_a.push_back(la);
            m_b.push_back((i % 8 == 0) ? la : lb);
            la = la[0] ? ((la >> 1) ^ 32'h80200003) : (la >> 1);
            lb = lb[0] ? ((lb >> 1) ^ 32'h80200003) : (lb >> 1);
         end
         m_c.push_back(ops[i % 5]);
         g = ref_alu(m_a[i], m_b[i], m_c[i]);
         o = alu_fn(m_a[i], m_b[i], m_c[i], fault);
         if (o[31:0] != g || o[32] != (g == 32'd0)) begin
            if (exp_err == 0) exp_ffi = i;
            if (exp_err < 65535) exp_err++;
         end
      end
   endtask

   task automatic run(input bit use5, input int n, input bit poke);
      build_model(n);
      sel5 = use5;
      @(negedge clk);
      if (use5) start5 = 1'b1; else startd = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0; startd = 1'b0;
      chk("start_busy", v_busy, 1); chk("start_done", v_done, 0);
      chk("start_err", v_err, 0);   chk("start_ffi", v_ffi, 0);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); @(negedge clk);
         chk("vec_a", v_a, m_a[k]);
         chk("vec_b", v_b, m_b[k]);
         chk("vec_ctl", v_c, m_c[k]);
         chk("run_busy", v_busy, 1);
         if (k == n - 1) chk("done_early", v_done, 0);
         if (use5 && k == 4 && fault == 0) chk("slt_result", v_r, 32'd1);
         if (poke && k == 2) begin
            if (use5) start5 = 1'b1; else startd = 1'b1;
         end
         @(posedge clk); #1;
         start5 = 1'b0; startd = 1'b0;
      end
      chk("done", v_done, 1); chk("end_busy", v_busy, 0);
      chk("err_count", v_err, exp_err); chk("first_fail", v_ffi, exp_ffi);
      chk("pass", v_pass, (exp_err == 0) ? 1 : 0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_a", v_a, 0); chk("rst_b", v_b, 0); chk("rst_ctl", v_c, 0);
      chk("rst_busy", v_busy, 0); chk("rst_done", v_done, 0); chk("rst_pass", v_pass, 0);
      chk("rst_err", v_err, 0); chk("rst_ffi", v_ffi, 0);
   endtask

   initial begin
      #1 sel5 = 1'b0; #1 chk_reset_vals();
      sel5 = 1'b1; #1 chk_reset_vals();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      fault = 0; run(1'b1, 5, 1'b0);
      fault = 0; run(1'b0, 256, 1'b0);
      fault = 1; run(1'b1, 5, 1'b0);
      chk("slt_unsigned_err", v_err, 1); chk("slt_unsigned_ffi", v_ffi, 4);
      // restart from DONE with a mid-run start pulse that must be ignored
      fault = 0; run(1'b1, 5, 1'b1);
      fault = 1; run(1'b0, 256, 1'b0);
      fault = 2; run(1'b0, 256, 1'b0);
      chk("zero_stuck_ffi", v_ffi, 0);

      // abort during CHECK of vector 100, then rerun from scratch
      fault = 0;
      sel5 = 1'b0;
      build_model(256);
      @(negedge clk); startd = 1'b1;
      @(posedge clk); #1 startd = 1'b0;
      repeat (201) @(posedge clk);
      @(negedge clk);
      chk("pre_abort_a", v_a, m_a[100]);
      rst = 1'b1;
      #1 chk_reset_vals();
      sel5 = 1'b1; #1 chk_reset_vals();
      @(negedge clk); rst = 1'b0;
      run(1'b0, 256, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

Built-in self-test initiator for the pipeline's combinational ALU. It drives the ALU's `a`, `b` and `control` inputs with a fixed corner-case set followed by pseudo-random operands. It checks each `result`/`zero` pair against an internal golden model and reports pass/fail, the error count and the index of the first failing vector. It sits beside the EX stage and is muxed onto the ALU inputs only during test mode.

## Interface
Parameters:
- `NUM_VECTORS`, 256: total vectors per run, including the 5 corner vectors; legal range 5..65535.
- `SEED`, 32'hACE12345: initial value of the operand-A LFSR; the operand-B LFSR is seeded with `~SEED`. Must be nonzero and not all-ones.

Ports:
- `clk` input 1: single clock; all state on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a run when sampled high in IDLE or DONE; ignored while busy.
- `a` output 32: ALU operand A; registered.
- `b` output 32: ALU operand B; registered.
- `control` output 3: ALU op select; registered.
- `result` input 32: ALU result.
- `zero` input 1: ALU zero flag.
- `busy` output 1: high in DRIVE and CHECK.
- `done` output 1: high in DONE.
- `pass` output 1: valid when `done`; 1 iff `err_count` == 0.
- `err_count` output 16: number of mismatching vectors, saturating at 16'hFFFF.
- `first_fail_idx` output 16: index of the first mismatching vector; 0 if none.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE or DONE with `start`=1:
  - clear `idx`, `err_count` and `first_fail_idx`;
  - load the A LFSR with `SEED` and the B LFSR with `~SEED`;
  - go to DRIVE.
- DRIVE: register `a`, `b` and `control` for vector `idx`, then go to CHECK.
- CHECK: the outputs are held and the ALU settles combinationally.
  - Compare `result` against `exp`, and `zero` against (`exp`==0).
  - On any mismatch, increment `err_count`, saturating at 16'hFFFF.
  - If `err_count` was 0 before the increment, set `first_fail_idx`=`idx`.
  - Step both LFSRs when `idx` ≥ 5.
  - If `idx` == `NUM_VECTORS`-1, go to DONE; otherwise increment `idx` and go to DRIVE.
- Op select: `control` = OPS[`idx` mod 5], where OPS = {010 add, 110 sub, 000 and, 001 or, 111 slt}.
- Corner vectors (`idx` 0..4, in order):
  - 0: (0, 0) add
  - 1: (FFFFFFFF, 00000001) sub
  - 2: (80000000, 7FFFFFFF) and
  - 3: (0F0F0F0F, F0F0F0F0) or
  - 4: (80000000, 7FFFFFFF) slt
- Random vectors (`idx` ≥ 5):
  - `a` = A LFSR value; `b` = B LFSR value.
  - Exception: when `idx` mod 8 == 0, `b` = `a`, which exercises `zero` on sub and slt.
- LFSRs: 32-bit Galois, taps mask 32'h80200003; they shift right with the feedback XOR applied when the LSB is 1.
- Golden model:
  - add/sub: modulo 2^32;
  - and/or: bitwise;
  - slt: signed two's-complement compare, `exp` = 32'd1 if $signed(`a`) < $signed(`b`), else 32'd0.
- DONE: hold `err_count`, `first_fail_idx` and `pass`, and hold `a`/`b`/`control` at the last vector until `start` or `rst`.

## Timing
- Reset (async, immediate): state IDLE; `a`=0, `b`=0, `control`=000; `busy`, `done`, `pass`=0; `err_count`, `first_fail_idx`=0; LFSRs loaded with `SEED` and `~SEED`.
- Start-to-done:
  - `start` sampled at edge E0 puts the FSM in DRIVE, with `busy`=1 after E0.
  - Each vector takes 2 cycles: DRIVE, then CHECK.
  - `done` rises after edge E0 + 2·`NUM_VECTORS`.
- The comparison uses `result`/`zero` sampled at the edge ending CHECK. The ALU path from registered `a`/`b`/`control` back to these inputs must close in one cycle.
- `start` asserted while busy has no effect.
- `start` in DONE restarts on the next edge: `done` falls and counters clear in the same cycle.
- `rst` asserted mid-run aborts immediately with no partial results retained.
- `err_count` at 16'hFFFF stays there.
- `first_fail_idx` never changes after the first failure within a run.

## Test plan
- Correct ALU model, `NUM_VECTORS`=5, start pulse → `done` 10 cycles after the start edge, `pass`=1, `err_count`=0. Observed vector 4 is `a`=80000000, `b`=7FFFFFFF, `control`=111, `result`=1.
- Correct ALU, default parameters → `done` after 512 cycles, `pass`=1. On vector 8, `b` equals `a`.
- ALU with slt done as an unsigned compare, `NUM_VECTORS`=5 → `err_count`=1, `first_fail_idx`=4, `pass`=0.
- ALU with `zero` stuck at 0 → the first failure is at `idx` 0 (add 0+0), so `first_fail_idx`=0 and `err_count` ≥ 2.
- Assert `rst` during CHECK of vector 100 → all outputs return to their reset values in the same cycle. A fresh `start` reproduces the identical `a`/`b` sequence from the start of the run.
- Pulse `start` while `busy`, then again in DONE → the first pulse is ignored. The second begins a new run: `done` drops and `err_count` clears.
